// File: rtl/param_systolic_tile.sv
// Output-stationary systolic matrix-multiply tile.
// A columns and B rows stream in unskewed; the tile skews them internally,
// accumulates C = sum_k A[:,k] * B[k,:] (mod 2^DW) in a ROWS x COLS PE grid,
// then drains C one row per handshake.
module param_systolic_tile #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 16,
    parameter int KW   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     START,
    input  logic [KW-1:0]            K_LEN,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [ROWS*DW-1:0]       A_IN,
    input  logic [COLS*DW-1:0]       B_IN,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [COLS*DW-1:0]       OUT_ROW,
    output logic [$clog2(ROWS)-1:0]  OUT_IDX,
    output logic                     BUSY,
    output logic                     DONE
);

    localparam int IW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS + COLS + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [KW-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [FW-1:0]  flush_cnt_reg, flush_cnt_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic           done_reg, done_next;
    logic           advance;   // grid shifts and accumulates this cycle
    logic           clear;     // job start: wipe grid and skew registers

    // Next-state, counter and grid-control decode
    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        idx_next       = idx_reg;
        done_next      = done_reg;
        advance        = 1'b0;
        clear          = 1'b0;
        if (EN) begin
            done_next = 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        clear          = 1'b1;
                        beat_cnt_next  = K_LEN;
                        flush_cnt_next = '0;
                        idx_next       = '0;
                        state_next     = (K_LEN == '0) ? S_DRAIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (IN_VALID) begin
                        advance = 1'b1;
                        if (beat_cnt_reg == KW'(1)) begin
                            beat_cnt_next = '0;
                            state_next    = S_FLUSH;
                        end else begin
                            beat_cnt_next = beat_cnt_reg - KW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // ROWS+COLS-1 zero-injection advances push the last
                    // operands through to the far corner PE.
                    advance = 1'b1;
                    if (flush_cnt_reg == FW'(ROWS + COLS - 2)) begin
                        flush_cnt_next = '0;
                        state_next     = S_DRAIN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg + FW'(1);
                    end
                end
                S_DRAIN: begin
                    if (OUT_READY) begin
                        if (idx_reg == IW'(ROWS - 1)) begin
                            idx_next   = '0;
                            done_next  = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            beat_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            idx_reg       <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
            idx_reg       <= idx_next;
            done_reg      <= done_next;
        end
    end

    assign IN_READY  = (state_reg == S_LOAD);
    assign OUT_VALID = (state_reg == S_DRAIN);
    assign BUSY      = (state_reg != S_IDLE);
    assign DONE      = done_reg;
    assign OUT_IDX   = idx_reg;

    // Operands entering the skew stage: live data in LOAD, zeros in FLUSH
    logic [DW-1:0] a_edge [ROWS];
    logic [DW-1:0] b_edge [COLS];

    genvar gi, gj;

    // A skew: lane r is delayed by r advances before entering column 0
    for (gi = 0; gi < ROWS; gi++) begin : g_askew
        logic [DW-1:0] a_inj;
        assign a_inj = (state_reg == S_LOAD) ? A_IN[gi*DW +: DW] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_inj;
        end else begin : g_chain
            logic [DW-1:0] sk_reg [gi];
            // Shift the skew chain on each grid advance
            always_ff @(posedge CLK) begin
                if (RST || clear) begin
                    for (int i = 0; i < gi; i++) sk_reg[i] <= '0;
                end else if (advance) begin
                    sk_reg[0] <= a_inj;
                    for (int i = 1; i < gi; i++) sk_reg[i] <= sk_reg[i-1];
                end
            end
            assign a_edge[gi] = sk_reg[gi-1];
        end
    end

    // B skew: lane c is delayed by c advances before entering row 0
    for (gi = 0; gi < COLS; gi++) begin : g_bskew
        logic [DW-1:0] b_inj;
        assign b_inj = (state_reg == S_LOAD) ? B_IN[gi*DW +: DW] : '0;
        if (gi == 0) begin : g_direct
            assign b_edge[gi] = b_inj;
        end else begin : g_chain
            logic [DW-1:0] sk_reg [gi];
            // Shift the skew chain on each grid advance
            always_ff @(posedge CLK) begin
                if (RST || clear) begin
                    for (int i = 0; i < gi; i++) sk_reg[i] <= '0;
                end else if (advance) begin
                    sk_reg[0] <= b_inj;
                    for (int i = 1; i < gi; i++) sk_reg[i] <= sk_reg[i-1];
                end
            end
            assign b_edge[gi] = sk_reg[gi-1];
        end
    end

    // PE grid: a flows right, b flows down, each PE keeps its own sum
    logic [DW-1:0] acc_w   [ROWS][COLS];
    logic [DW-1:0] a_out_w [ROWS][COLS-1];
    logic [DW-1:0] b_out_w [ROWS-1][COLS];

    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            logic [DW-1:0] a_w, b_w, acc_reg;
            if (gj == 0) begin : g_ae
                assign a_w = a_edge[gi];
            end else begin : g_ai
                assign a_w = a_out_w[gi][gj-1];
            end
            if (gi == 0) begin : g_be
                assign b_w = b_edge[gj];
            end else begin : g_bi
                assign b_w = b_out_w[gi-1][gj];
            end

            // Multiply-accumulate, wrapping at DW bits
            always_ff @(posedge CLK) begin
                if (RST || clear)
                    acc_reg <= '0;
                else if (advance)
                    acc_reg <= acc_reg + a_w * b_w;
            end
            assign acc_w[gi][gj] = acc_reg;

            if (gj < COLS - 1) begin : g_pass_a
                logic [DW-1:0] a_reg;
                // Forward a to the right-hand neighbour
                always_ff @(posedge CLK) begin
                    if (RST || clear)  a_reg <= '0;
                    else if (advance)  a_reg <= a_w;
                end
                assign a_out_w[gi][gj] = a_reg;
            end
            if (gi < ROWS - 1) begin : g_pass_b
                logic [DW-1:0] b_reg;
                // Forward b to the neighbour below
                always_ff @(posedge CLK) begin
                    if (RST || clear)  b_reg <= '0;
                    else if (advance)  b_reg <= b_w;
                end
                assign b_out_w[gi][gj] = b_reg;
            end
        end
    end

    // Drain mux: the row selected by the drain index
    for (gj = 0; gj < COLS; gj++) begin : g_out
        assign OUT_ROW[gj*DW +: DW] = acc_w[idx_reg][gj];
    end

endmodule

// File: tb/tb_param_systolic_tile.sv
// Scoreboard bench for param_systolic_tile: jobs are modelled as plain
// matrix products, expected rows queued at issue, a negedge monitor checks
// every drained row and the DONE pulse.
module tb_param_systolic_tile;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int DW = 16;
    localparam int KW = 8;

    logic              clk;
    logic              rst, en, start;
    logic [KW-1:0]     k_len;
    logic              in_valid, in_ready;
    logic [R*DW-1:0]   a_in;
    logic [C*DW-1:0]   b_in;
    logic              out_valid, out_ready;
    logic [C*DW-1:0]   out_row;
    logic [2:0]        out_idx;
    logic              busy, done;

    param_systolic_tile #(.ROWS(R), .COLS(C), .DW(DW), .KW(KW)) dut (
        .CLK(clk), .RST(rst), .EN(en), .START(start), .K_LEN(k_len),
        .IN_VALID(in_valid), .IN_READY(in_ready), .A_IN(a_in), .B_IN(b_in),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_ROW(out_row),
        .OUT_IDX(out_idx), .BUSY(busy), .DONE(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [127:0] row;
        int           idx;
    } exp_t;

    exp_t          sb_q[$];
    logic [127:0]  a_q[$];
    logic [127:0]  b_q[$];
    logic [127:0]  exp_row2;
    int            compared   = 0;
    int            mismatched = 0;
    bit            last_hs_pending = 0;
    bit            prev_en = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion", nm);
    endtask

    // Monitor: checks DONE timing and pops the scoreboard on each row handshake
    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        if (last_hs_pending)
            chk("done_pulse", 128'(done), 128'(1));
        else if (prev_en)
            chk("done_quiet", 128'(done), 128'(0));
        hs = out_valid && out_ready && en && !rst;
        if (hs) begin
            if (sb_q.size() == 0) begin
                note_fail("unexpected_row");
            end else begin
                e = sb_q.pop_front();
                chk("row_idx", 128'(out_idx), 128'(e.idx));
                chk("row_data", out_row, e.row);
                $display("row %0d drained: %h", e.idx, out_row);
            end
        end
        last_hs_pending = hs && (out_idx == 3'(R - 1));
        prev_en = en || rst;
    end

    // Reference model: C[r][c] = sum_k A_k[r] * B_k[c], low DW bits
    task automatic push_expected();
        exp_t         e;
        logic [127:0] av, bv;
        int unsigned  s;
        for (int r = 0; r < R; r++) begin
            e.row = '0;
            for (int c = 0; c < C; c++) begin
                s = 0;
                for (int k = 0; k < a_q.size(); k++) begin
                    av = a_q[k];
                    bv = b_q[k];
                    s += 32'(av[r*DW +: DW]) * 32'(bv[c*DW +: DW]);
                end
                e.row[c*DW +: DW] = s[15:0];
            end
            e.idx = r;
            if (r == 2) exp_row2 = e.row;
            sb_q.push_back(e);
        end
    endtask

    task automatic gen_random(input int k);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < k; i++) begin
            a_q.push_back({$urandom, $urandom, $urandom, $urandom});
            b_q.push_back({$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        $display("job start K_LEN=%0d", k);
    endtask

    // mode 0: every beat valid; 1: valid 1,0,1,0,...; 2: random valid + random EN;
    // 3: random valid. noise pulses START during the load.
    task automatic load_beats(input int mode, input bit noise);
        int idx = 0;
        int phase = 0;
        bit v, e, rdy;
        while (idx < a_q.size() && phase < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 2 == 0) : 1'($urandom_range(0, 1));
            e = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            en = e;
            a_in = v ? a_q[idx] : {$urandom, $urandom, $urandom, $urandom};
            b_in = v ? b_q[idx] : {$urandom, $urandom, $urandom, $urandom};
            start = noise && (phase == 1);
            if (noise && phase == 1) k_len = KW'(7);
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (v && rdy && e) idx++;
            phase++;
        end
        if (idx < a_q.size()) note_fail("load_timeout");
        in_valid = 1'b0;
        en = 1'b1;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
    endtask

    // mode 0: ready held high; 1: random ready; 2: hold row 2 for 5 cycles
    // with a stray START; 3: IN_READY must stay low.
    task automatic wait_idle(input int mode);
        int hold = 0;
        int cyc = 0;
        bit ok = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy && sb_q.size() == 0) begin
                ok = 1;
                break;
            end
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && out_idx == 3'd2 && hold < 5) begin
                        out_ready = 1'b0;
                        chk("hold_idx", 128'(out_idx), 128'(2));
                        chk("hold_row", out_row, exp_row2);
                        start = (hold == 2);
                        k_len = KW'(0);
                        hold++;
                    end else begin
                        out_ready = 1'b1;
                        start = 1'b0;
                    end
                end
                3: chk("k0_no_in_ready", 128'(in_ready), 128'(0));
                default: out_ready = 1'b1;
            endcase
        end
        if (!ok) note_fail("drain_timeout");
        if (mode == 2 && hold != 5) note_fail("hold_not_reached");
        out_ready = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        logic [127:0] v;
        rst = 1'b1; en = 1'b1; start = 1'b0; k_len = '0;
        in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_idx", 128'(out_idx), 128'(0));
        chk("rst_out_row", out_row, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // identity x identity
        a_q.delete(); b_q.delete();
        for (int k = 0; k < 8; k++) begin
            v = '0;
            v[k*DW +: DW] = 16'd1;
            a_q.push_back(v);
            b_q.push_back(v);
        end
        push_expected();
        start_job(8);
        load_beats(0, 0);
        wait_idle(0);

        // constant 2*3 over 3 beats with gapped valid, plus flush length
        a_q.delete(); b_q.delete();
        for (int k = 0; k < 3; k++) begin
            a_q.push_back({8{16'd2}});
            b_q.push_back({8{16'd3}});
        end
        push_expected();
        start_job(3);
        load_beats(1, 0);
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (out_valid) break;
            cnt++;
        end
        chk("flush_len", 128'(cnt), 128'(15));
        wait_idle(0);

        // wrap-around
        a_q.delete(); b_q.delete();
        a_q.push_back({8{16'hFFFF}});
        b_q.push_back({8{16'hFFFF}});
        push_expected();
        start_job(1);
        load_beats(0, 0);
        wait_idle(0);

        // zero-length job goes straight to DRAIN
        a_q.delete(); b_q.delete();
        push_expected();
        start_job(0);
        @(negedge clk);
        chk("k0_drain_next", 128'(out_valid), 128'(1));
        chk("k0_in_ready", 128'(in_ready), 128'(0));
        wait_idle(3);

        // back-pressure on row 2, stray START pulses during load and drain
        gen_random(4);
        push_expected();
        start_job(4);
        load_beats(3, 1);
        wait_idle(2);

        // reset during FLUSH aborts the job
        gen_random(5);
        start_job(5);
        load_beats(0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_row", out_row, 128'(0));
        gen_random(6);
        push_expected();
        start_job(6);
        load_beats(2, 0);
        wait_idle(1);

        // randomized jobs
        for (int j = 0; j < 6; j++) begin
            gen_random($urandom_range(1, 20));
            push_expected();
            start_job(a_q.size());
            load_beats($urandom_range(0, 3), 0);
            wait_idle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/param_systolic_tile.md
PARAM_SYSTOLIC_TILE -- requirements
Module: param_systolic_tile

Interface
REQ-001 SHALL provide parameter ROWS, default 8, meaning the number of PE rows (A operand lanes), legal range 2..16.
REQ-002 SHALL provide parameter COLS, default 8, meaning the number of PE columns (B operand lanes), legal range 2..16.
REQ-003 SHALL provide parameter DW, default 16, meaning the operand and accumulator width in bits.
REQ-004 SHALL provide parameter KW, default 8, meaning the width of the reduction-length field.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL provide port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL provide port RST, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL provide port EN, input, 1 bit, global enable; when low, all state holds.
REQ-009 SHALL provide port START, input, 1 bit, job request, sampled only in IDLE.
REQ-010 SHALL provide port K_LEN, input, KW bits, reduction length, captured with START.
REQ-011 SHALL provide port IN_VALID, input, 1 bit, operand beat valid.
REQ-012 SHALL provide port IN_READY, output, 1 bit, operand beat accepted when high together with IN_VALID.
REQ-013 SHALL provide port A_IN, input, ROWS*DW bits, one unskewed A column; lane r is bits [r*DW +: DW].
REQ-014 SHALL provide port B_IN, input, COLS*DW bits, one unskewed B row; lane c is bits [c*DW +: DW].
REQ-015 SHALL provide port OUT_VALID, output, 1 bit, result row valid.
REQ-016 SHALL provide port OUT_READY, input, 1 bit, result row consumed when high together with OUT_VALID.
REQ-017 SHALL provide port OUT_ROW, output, COLS*DW bits, accumulators of the current drain row; lane c is C[row][c].
REQ-018 SHALL provide port OUT_IDX, output, $clog2(ROWS) bits, index of the row on OUT_ROW.
REQ-019 SHALL provide port BUSY, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-020 SHALL provide port DONE, output, 1 bit, one-cycle pulse when the last row is consumed.

Function
REQ-021 SHALL instantiate a ROWS x COLS output-stationary grid; on each advance, PE(r,c) sets acc <= acc + a*b (low DW bits, wrap mod 2^DW), passes a right and b down.
REQ-022 SHALL skew inputs internally: A lane r through r registers, B lane c through c registers, so element k reaches PE(r,c) on advance k+r+c.
REQ-023 SHALL use FSM states IDLE, LOAD, FLUSH and DRAIN; all transitions require EN=1.
REQ-024 SHALL, in IDLE with START=1, capture K_LEN, clear all accumulators and skew/pipeline registers, and go to LOAD (K_LEN>0) or DRAIN (K_LEN=0).
REQ-025 SHALL hold IN_READY=1 only in LOAD; each accepted beat advances the grid and decrements a beat counter; the last accepted beat moves the FSM to FLUSH.
REQ-026 SHALL freeze the grid (no shift, no accumulate) in LOAD cycles where IN_VALID=0.
REQ-027 SHALL advance the grid with zero operands injected for exactly ROWS+COLS-1 cycles in FLUSH, then go to DRAIN.
REQ-028 SHALL, in DRAIN, present OUT_VALID=1, with OUT_IDX starting at 0 and incrementing on each handshake; OUT_ROW is stable while OUT_READY=0.
REQ-029 SHALL, on the handshake with OUT_IDX=ROWS-1, pulse DONE and return to IDLE; accumulators retain their values until the next START.
REQ-030 SHALL ignore START outside IDLE, and ignore IN_VALID outside LOAD.
REQ-031 SHALL freeze state, counters and the grid while EN=0; outputs hold their last values.

Reset
REQ-032 SHALL, on RST=1 at a clock edge (priority over EN), enter IDLE and zero all accumulators, skew registers and counters.
REQ-033 SHALL drive these reset values: IN_READY=0, OUT_VALID=0, OUT_IDX=0, OUT_ROW=0, BUSY=0, DONE=0.
REQ-034 SHALL abort the job when RST is asserted in LOAD, FLUSH or DRAIN, with no DONE pulse.

Verification
REQ-035 SHALL test defaults, K_LEN=8, A=B=identity streamed on 8 consecutive beats -> rows drained 0..7 equal identity, with DONE one cycle after the row-7 handshake.
REQ-036 SHALL test K_LEN=3, all A lanes=2, all B lanes=3, with IN_VALID toggling 1,0,1,0,1 -> every OUT_ROW lane=18, FLUSH lasting exactly 15 cycles.
REQ-037 SHALL test K_LEN=1, A=B=16'hFFFF -> every lane=16'h0001 (wrap-around).
REQ-038 SHALL test K_LEN=0 -> DRAIN entered the cycle after START, all rows zero, and IN_READY never asserted.
REQ-039 SHALL test OUT_READY held low for 5 cycles on row 2 -> OUT_IDX=2 with OUT_ROW unchanged, and START pulsed mid-job is ignored.
REQ-040 SHALL test RST asserted in FLUSH -> next cycle BUSY=0 with no DONE, and a new job then gives correct results from cleared accumulators.
